// File: rtl/snake_head_stepper_if.sv
// ---------------------------------------------------------------------------
// snake_head_stepper_if
//   Bundles the game-side controls and the head-position results of the
//   snake head stepper.
//   Signals:
//     tick       game timer step strobe (one cycle)
//     pause      high: tick ignored while idle
//     dir_valid  direction request strobe
//     dir_in     requested direction (00 up, 01 right, 10 down, 11 left)
//     head_x     current head column
//     head_y     current head row
//     dir_cur    direction used by the most recent step
//     busy       high while a step is being computed/applied
//     step_done  one-cycle pulse when head_x/head_y change
//     wrapped    one-cycle pulse with step_done if the step crossed an edge
//   Modports:
//     master  drives the requests, observes the head (game controller / bench)
//     slave   the stepper itself
// ---------------------------------------------------------------------------
interface snake_head_stepper_if;
  logic       tick;
  logic       pause;
  logic       dir_valid;
  logic [1:0] dir_in;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir_cur;
  logic       busy;
  logic       step_done;
  logic       wrapped;

  modport master (
    output tick, pause, dir_valid, dir_in,
    input  head_x, head_y, dir_cur, busy, step_done, wrapped
  );

  modport slave (
    input  tick, pause, dir_valid, dir_in,
    output head_x, head_y, dir_cur, busy, step_done, wrapped
  );
endinterface

// File: rtl/snake_head_stepper.sv
// ---------------------------------------------------------------------------
// snake_head_stepper
//   Holds the snake head grid coordinate and travel direction and advances
//   the head by one cell per accepted game tick, wrapping at the grid edges.
//   Player direction requests are buffered in a pending register; requests
//   that would reverse the snake onto itself are dropped.
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    snake_head_stepper_if.slave (tick/pause/direction in,
//            head position, direction and step status out)
//   Timing: tick sampled in cycle n -> busy in n+1..n+2, new head plus
//   step_done (and wrapped) in n+2; the next tick is accepted from n+3.
// ---------------------------------------------------------------------------
module snake_head_stepper #(
  parameter int         GRID_COLS = 32,
  parameter int         GRID_ROWS = 24,
  parameter int         START_X   = 16,
  parameter int         START_Y   = 12,
  parameter logic [1:0] START_DIR = 2'b01
) (
  input logic                  clk,
  input logic                  rst_n,
  snake_head_stepper_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [4:0] MAX_X   = 5'(GRID_COLS - 1);
  localparam logic [4:0] MAX_Y   = 5'(GRID_ROWS - 1);
  localparam logic [4:0] INIT_X  = 5'(START_X);
  localparam logic [4:0] INIT_Y  = 5'(START_Y);
  localparam logic [4:0] ONE     = 5'd1;

  state_t     state;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir_cur;
  logic [1:0] dir_pend;
  logic       busy;
  logic       step_done;
  logic       wrapped;

  logic [4:0] next_x;
  logic [4:0] next_y;
  logic       next_wrap;
  logic       req_ok;

  // A request is accepted unless it points straight back along dir_cur.
  // While busy, dir_cur already holds the direction of the step in flight.
  assign req_ok = bus.dir_valid && (bus.dir_in != (dir_cur ^ 2'b10));

  // Next cell for the committed direction. Decrement is A + ~B + 1.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_x    = head_x;
    next_y    = head_y;
    next_wrap = 1'b0;
    unique case (dir_cur)
      DIR_UP: begin
        if (head_y == 5'd0) begin
          next_y    = MAX_Y;
          next_wrap = 1'b1;
        end else begin
          next_y = head_y + ~ONE + ONE;
        end
      end
      DIR_DOWN: begin
        if (head_y == MAX_Y) begin
          next_y    = 5'd0;
          next_wrap = 1'b1;
        end else begin
          next_y = head_y + ONE;
        end
      end
      DIR_LEFT: begin
        if (head_x == 5'd0) begin
          next_x    = MAX_X;
          next_wrap = 1'b1;
        end else begin
          next_x = head_x + ~ONE + ONE;
        end
      end
      DIR_RIGHT: begin
        if (head_x == MAX_X) begin
          next_x    = 5'd0;
          next_wrap = 1'b1;
        end else begin
          next_x = head_x + ONE;
        end
      end
      default: begin
        next_x = head_x;
      end
    endcase
  end

  // Single sequential block: FSM, pending direction and registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      head_x    <= INIT_X;
      head_y    <= INIT_Y;
      dir_cur   <= START_DIR;
      dir_pend  <= START_DIR;
      busy      <= 1'b0;
      step_done <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      step_done <= 1'b0;
      wrapped   <= 1'b0;
      if (req_ok) begin
        dir_pend <= bus.dir_in;
      end
      unique case (state)
        IDLE: begin
          if (bus.tick && !bus.pause) begin
            state <= CALC;
            busy  <= 1'b1;
            // A request arriving with the tick wins over the older pending one.
            dir_cur <= req_ok ? bus.dir_in : dir_pend;
          end
        end
        CALC: begin
          // Head is loaded on leaving CALC so it appears together with
          // step_done during UPDATE (two cycles after the tick).
          state     <= UPDATE;
          head_x    <= next_x;
          head_y    <= next_y;
          step_done <= 1'b1;
          wrapped   <= next_wrap;
        end
        UPDATE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.head_x    = head_x;
  assign bus.head_y    = head_y;
  assign bus.dir_cur   = dir_cur;
  assign bus.busy      = busy;
  assign bus.step_done = step_done;
  assign bus.wrapped   = wrapped;

endmodule
